// File: rtl/credit_switch_allocator_if.sv
// Request, credit-return and grant bundle between the input block, the crossbar
// and credit_switch_allocator.
interface credit_switch_allocator_if #(
  parameter int PORT_NUM  = 5,
  parameter int VC_NUM    = 4,
  parameter int PORT_SIZE = $clog2(PORT_NUM),
  parameter int VC_SIZE   = $clog2(VC_NUM)
);
  logic [PORT_NUM*VC_NUM-1:0]           switch_request_i;
  logic [PORT_NUM*VC_NUM*PORT_SIZE-1:0] out_port_i;
  logic [PORT_NUM*VC_NUM*VC_SIZE-1:0]   downstream_vc_i;
  logic [PORT_NUM-1:0]                  credit_valid_i;
  logic [PORT_NUM*VC_SIZE-1:0]          credit_vc_i;
  logic [PORT_NUM-1:0]                  valid_sel_o;
  logic [PORT_NUM*VC_SIZE-1:0]          vc_sel_o;
  logic [PORT_NUM-1:0]                  valid_flit_o;
  logic [PORT_NUM*PORT_SIZE-1:0]        input_vc_sel_o;
  logic                                 credit_err_o;

  modport master (
    output switch_request_i, out_port_i, downstream_vc_i, credit_valid_i, credit_vc_i,
    input  valid_sel_o, vc_sel_o, valid_flit_o, input_vc_sel_o, credit_err_o
  );

  modport slave (
    input  switch_request_i, out_port_i, downstream_vc_i, credit_valid_i, credit_vc_i,
    output valid_sel_o, vc_sel_o, valid_flit_o, input_vc_sel_o, credit_err_o
  );
endinterface

// File: rtl/credit_switch_allocator.sv
// Two-stage round-robin switch allocator (input VC arbitration, then output port
// arbitration) gated by per-output-VC downstream credit counters; grants are registered.
module credit_switch_allocator #(
  parameter int PORT_NUM     = 5,
  parameter int VC_NUM       = 4,
  parameter int CREDIT_DEPTH = 8,
  parameter int PORT_SIZE    = $clog2(PORT_NUM),
  parameter int VC_SIZE      = $clog2(VC_NUM),
  parameter int CNT_SIZE     = $clog2(CREDIT_DEPTH + 1)
) (
  input logic                      clk,
  input logic                      rst,
  credit_switch_allocator_if.slave sa
);

  logic [PORT_SIZE-1:0] w_out_port [PORT_NUM][VC_NUM];
  logic [VC_SIZE-1:0]   w_dvc      [PORT_NUM][VC_NUM];
  logic                 w_req      [PORT_NUM][VC_NUM];
  logic [VC_SIZE-1:0]   w_cr_vc    [PORT_NUM];

  logic                 w_cand_valid [PORT_NUM];
  logic [VC_SIZE-1:0]   w_cand_vc    [PORT_NUM];
  logic [PORT_SIZE-1:0] w_cand_op    [PORT_NUM];
  logic [VC_SIZE-1:0]   w_cand_dvc   [PORT_NUM];

  logic                 w_win_valid [PORT_NUM];
  logic [PORT_SIZE-1:0] w_win_ip    [PORT_NUM];
  logic [VC_SIZE-1:0]   w_win_dvc   [PORT_NUM];
  logic                 w_granted   [PORT_NUM];

  logic                 w_dec [PORT_NUM][VC_NUM];
  logic                 w_inc [PORT_NUM][VC_NUM];

  logic [CNT_SIZE-1:0]           r_credit [PORT_NUM][VC_NUM];
  logic [VC_SIZE-1:0]            r_vc_ptr [PORT_NUM];
  logic [PORT_SIZE-1:0]          r_ip_ptr [PORT_NUM];
  logic [PORT_NUM-1:0]           r_valid_sel;
  logic [PORT_NUM*VC_SIZE-1:0]   r_vc_sel;
  logic [PORT_NUM-1:0]           r_valid_flit;
  logic [PORT_NUM*PORT_SIZE-1:0] r_input_vc_sel;
  logic                          r_credit_err;

  // Flattened bus fields into per-port/per-VC views.
  always_comb begin
    for (int p = 0; p < PORT_NUM; p++) begin
      w_cr_vc[p] = sa.credit_vc_i[p*VC_SIZE +: VC_SIZE];
      for (int v = 0; v < VC_NUM; v++) begin
        w_out_port[p][v] = sa.out_port_i[(p*VC_NUM+v)*PORT_SIZE +: PORT_SIZE];
        w_dvc[p][v]      = sa.downstream_vc_i[(p*VC_NUM+v)*VC_SIZE +: VC_SIZE];
      end
    end
  end

  // A request is eligible only for a real output port with downstream space left.
  always_comb begin
    for (int p = 0; p < PORT_NUM; p++) begin
      for (int v = 0; v < VC_NUM; v++) begin
        // NOTE: every combinational output gets a default before any condition, so no latch is inferred.
        w_req[p][v] = 1'b0;
        if (sa.switch_request_i[p*VC_NUM+v] && (int'(w_out_port[p][v]) < PORT_NUM)) begin
          w_req[p][v] = (r_credit[w_out_port[p][v]][w_dvc[p][v]] != '0);
        end
      end
    end
  end

  // Stage 1: each input picks one eligible VC, searching upward from its pointer.
  always_comb begin
    int idx;
    idx = 0;
    for (int p = 0; p < PORT_NUM; p++) begin
      w_cand_valid[p] = 1'b0;
      w_cand_vc[p]    = '0;
      for (int k = 0; k < VC_NUM; k++) begin
        idx = int'(r_vc_ptr[p]) + k;
        if (idx >= VC_NUM) idx = idx - VC_NUM;
        if (!w_cand_valid[p] && w_req[p][idx]) begin
          w_cand_valid[p] = 1'b1;
          w_cand_vc[p]    = VC_SIZE'(idx);
        end
      end
      w_cand_op[p]  = w_out_port[p][w_cand_vc[p]];
      w_cand_dvc[p] = w_dvc[p][w_cand_vc[p]];
    end
  end

  // Stage 2: each output picks one input among the candidates aimed at it.
  always_comb begin
    int idx;
    idx = 0;
    for (int o = 0; o < PORT_NUM; o++) begin
      w_win_valid[o] = 1'b0;
      w_win_ip[o]    = '0;
      w_win_dvc[o]   = '0;
      for (int k = 0; k < PORT_NUM; k++) begin
        idx = int'(r_ip_ptr[o]) + k;
        if (idx >= PORT_NUM) idx = idx - PORT_NUM;
        if (!w_win_valid[o] && w_cand_valid[idx] && (int'(w_cand_op[idx]) == o)) begin
          w_win_valid[o] = 1'b1;
          w_win_ip[o]    = PORT_SIZE'(idx);
          w_win_dvc[o]   = w_cand_dvc[idx];
        end
      end
    end
  end

  always_comb begin
    for (int p = 0; p < PORT_NUM; p++) begin
      w_granted[p] = 1'b0;
      for (int o = 0; o < PORT_NUM; o++) begin
        if (w_win_valid[o] && (int'(w_win_ip[o]) == p)) w_granted[p] = 1'b1;
      end
    end
  end

  // At most one decrement per counter per cycle: each output has a single winner.
  always_comb begin
    for (int o = 0; o < PORT_NUM; o++) begin
      for (int v = 0; v < VC_NUM; v++) begin
        w_dec[o][v] = w_win_valid[o] && (int'(w_win_dvc[o]) == v);
        w_inc[o][v] = sa.credit_valid_i[o] && (int'(w_cr_vc[o]) == v);
      end
    end
  end

  // NOTE: nonblocking assignments throughout, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid_sel    <= '0;
      r_vc_sel       <= '0;
      r_valid_flit   <= '0;
      r_input_vc_sel <= '0;
      r_credit_err   <= 1'b0;
      for (int p = 0; p < PORT_NUM; p++) begin
        r_vc_ptr[p] <= '0;
        r_ip_ptr[p] <= '0;
        // NOTE: the credit array is a register file, not RAM; each entry must load full credit on reset.
        for (int v = 0; v < VC_NUM; v++) r_credit[p][v] <= CNT_SIZE'(CREDIT_DEPTH);
      end
    end else begin
      for (int p = 0; p < PORT_NUM; p++) begin
        r_valid_sel[p]                  <= w_granted[p];
        r_vc_sel[p*VC_SIZE +: VC_SIZE]  <= w_granted[p] ? w_cand_vc[p] : '0;
        if (w_granted[p]) begin
          r_vc_ptr[p] <= (int'(w_cand_vc[p]) == VC_NUM - 1) ? '0 : w_cand_vc[p] + VC_SIZE'(1);
        end
      end
      for (int o = 0; o < PORT_NUM; o++) begin
        r_valid_flit[o]                        <= w_win_valid[o];
        r_input_vc_sel[o*PORT_SIZE +: PORT_SIZE] <= w_win_valid[o] ? w_win_ip[o] : '0;
        if (w_win_valid[o]) begin
          r_ip_ptr[o] <= (int'(w_win_ip[o]) == PORT_NUM - 1) ? '0 : w_win_ip[o] + PORT_SIZE'(1);
        end
      end
      // A simultaneous grant and return on one counter cancel out.
      for (int o = 0; o < PORT_NUM; o++) begin
        for (int v = 0; v < VC_NUM; v++) begin
          if (w_inc[o][v] && !w_dec[o][v]) begin
            if (r_credit[o][v] == CNT_SIZE'(CREDIT_DEPTH)) r_credit_err <= 1'b1;
            else r_credit[o][v] <= r_credit[o][v] + CNT_SIZE'(1);
          end else if (w_dec[o][v] && !w_inc[o][v]) begin
            r_credit[o][v] <= r_credit[o][v] - CNT_SIZE'(1);
          end
        end
      end
    end
  end

  assign sa.valid_sel_o    = r_valid_sel;
  assign sa.vc_sel_o       = r_vc_sel;
  assign sa.valid_flit_o   = r_valid_flit;
  assign sa.input_vc_sel_o = r_input_vc_sel;
  assign sa.credit_err_o   = r_credit_err;

endmodule

// File: tb/tb_credit_switch_allocator.sv
// Scoreboard bench for credit_switch_allocator: a queue-based reference model predicts
// every registered response; directed scenarios plus randomized traffic.
module tb_credit_switch_allocator;
  localparam int P  = 5;
  localparam int V  = 4;
  localparam int D  = 8;
  localparam int PS = 3;
  localparam int VS = 2;

  typedef struct packed {
    logic [P-1:0]    valid_sel;
    logic [P*VS-1:0] vc_sel;
    logic [P-1:0]    valid_flit;
    logic [P*PS-1:0] in_sel;
    logic            err;
  } resp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  credit_switch_allocator_if #(.PORT_NUM(P), .VC_NUM(V)) ifc ();

  credit_switch_allocator #(.PORT_NUM(P), .VC_NUM(V), .CREDIT_DEPTH(D)) dut (
    .clk (clk),
    .rst (rst),
    .sa  (ifc.slave)
  );

  resp_t exp_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  bit req   [P][V];
  int op    [P][V];
  int dvc   [P][V];
  bit cr_v  [P];
  int cr_vc [P];

  int m_credit [P][V];
  int m_vc_ptr [P];
  int m_ip_ptr [P];
  bit m_err;

  int grants_o3 = 0;
  int seq_ip4[$];
  int seq_vc1[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic resp_t act_vec();
    return {ifc.valid_sel_o, ifc.vc_sel_o, ifc.valid_flit_o, ifc.input_vc_sel_o, ifc.credit_err_o};
  endfunction

  task automatic model_reset();
    for (int o = 0; o < P; o++) begin
      m_vc_ptr[o] = 0;
      m_ip_ptr[o] = 0;
      for (int v = 0; v < V; v++) m_credit[o][v] = D;
    end
    m_err = 1'b0;
  endtask

  task automatic clear_stim();
    for (int p = 0; p < P; p++) begin
      cr_v[p] = 1'b0;
      cr_vc[p] = 0;
      for (int v = 0; v < V; v++) begin
        req[p][v] = 1'b0; op[p][v] = 0; dvc[p][v] = 0;
      end
    end
  endtask

  task automatic randomize_stim(input int req_pct, input int cr_pct);
    for (int p = 0; p < P; p++) begin
      cr_v[p]  = ($urandom_range(99) < cr_pct);
      cr_vc[p] = $urandom_range(V - 1);
      for (int v = 0; v < V; v++) begin
        req[p][v] = ($urandom_range(99) < req_pct);
        op[p][v]  = $urandom_range(7);
        dvc[p][v] = $urandom_range(V - 1);
      end
    end
  endtask

  task automatic apply_stim();
    for (int p = 0; p < P; p++) begin
      ifc.credit_valid_i[p]          = cr_v[p];
      ifc.credit_vc_i[p*VS +: VS]    = VS'(cr_vc[p]);
      for (int v = 0; v < V; v++) begin
        ifc.switch_request_i[p*V+v]            = req[p][v];
        ifc.out_port_i[(p*V+v)*PS +: PS]       = PS'(op[p][v]);
        ifc.downstream_vc_i[(p*V+v)*VS +: VS]  = VS'(dvc[p][v]);
      end
    end
  endtask

  // Reference model: one allocation round from the stimulus image, advancing model state.
  function automatic resp_t model_step();
    resp_t e;
    int    cand[P];
    bit    taken;
    e = '0;
    for (int p = 0; p < P; p++) begin
      cand[p] = -1;
      for (int k = 0; k < V; k++) begin
        int v = (m_vc_ptr[p] + k) % V;
        if (cand[p] < 0 && req[p][v] && op[p][v] < P) begin
          if (m_credit[op[p][v]][dvc[p][v]] > 0) cand[p] = v;
        end
      end
    end
    for (int o = 0; o < P; o++) begin
      taken = 1'b0;
      for (int k = 0; k < P; k++) begin
        int p = (m_ip_ptr[o] + k) % P;
        if (!taken && cand[p] >= 0) begin
          if (op[p][cand[p]] == o) begin
            int c = cand[p];
            taken = 1'b1;
            e.valid_flit[o]        = 1'b1;
            e.in_sel[o*PS +: PS]   = PS'(p);
            e.valid_sel[p]         = 1'b1;
            e.vc_sel[p*VS +: VS]   = VS'(c);
            m_credit[o][dvc[p][c]] = m_credit[o][dvc[p][c]] - 1;
            m_vc_ptr[p] = (c + 1) % V;
            m_ip_ptr[o] = (p + 1) % P;
          end
        end
      end
    end
    for (int o = 0; o < P; o++) begin
      if (cr_v[o]) begin
        if (m_credit[o][cr_vc[o]] == D) m_err = 1'b1;
        else m_credit[o][cr_vc[o]] = m_credit[o][cr_vc[o]] + 1;
      end
    end
    e.err = m_err;
    return e;
  endfunction

  // Drive one cycle at the falling edge and queue the response due after the next rising edge.
  task automatic step(input bit rst_val);
    @(negedge clk);
    rst = rst_val;
    apply_stim();
    if (!rst_val) begin
      model_reset();
      exp_q.push_back('0);
    end else begin
      exp_q.push_back(model_step());
    end
  endtask

  // Monitor: compares every registered response and logs grant sequences.
  initial begin
    resp_t act, e;
    forever begin
      @(posedge clk);
      #1;
      act = act_vec();
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sb_resp", act, e);
      end
      if (ifc.valid_flit_o[3]) grants_o3++;
      if (ifc.valid_flit_o[4]) seq_ip4.push_back(int'(ifc.input_vc_sel_o[4*PS +: PS]));
      if (ifc.valid_sel_o[1])  seq_vc1.push_back(int'(ifc.vc_sel_o[1*VS +: VS]));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    int exp_seq4[6];
    int exp_seq1[4];
    exp_seq4 = '{0, 1, 2, 0, 1, 2};
    exp_seq1 = '{0, 3, 0, 3};

    clear_stim();
    model_reset();
    apply_stim();
    #2 rst = 1'b0;
    #1 check("reset_outputs", act_vec(), '0);

    // Reset held with random requests
    repeat (5) begin
      randomize_stim(60, 30);
      step(1'b0);
    end
    clear_stim();
    step(1'b1);

    // Single grant in1 v2 -> out3 dvc1
    req[1][2] = 1'b1; op[1][2] = 3; dvc[1][2] = 1;
    step(1'b1);
    clear_stim();
    step(1'b1);
    check("single_valid_sel1", ifc.valid_sel_o[1], 1);
    check("single_vc_sel1", ifc.vc_sel_o[1*VS +: VS], 2);
    check("single_valid_flit3", ifc.valid_flit_o[3], 1);
    check("single_input_sel3", ifc.input_vc_sel_o[3*PS +: PS], 1);

    // Credit exhaustion on out3 dvc1, then one returned credit
    step(1'b0);
    step(1'b1);
    grants_o3 = 0;
    req[1][2] = 1'b1; op[1][2] = 3; dvc[1][2] = 1;
    repeat (10) step(1'b1);
    cr_v[3] = 1'b1; cr_vc[3] = 1;
    step(1'b1);
    check("exhaust_8_grants", grants_o3, 8);
    cr_v[3] = 1'b0;
    step(1'b1);
    step(1'b1);
    check("credit_return_grant", grants_o3, 9);
    clear_stim();
    step(1'b1);
    check("stall_after_return", grants_o3, 9);

    // Output fairness on out4
    step(1'b0);
    step(1'b1);
    seq_ip4.delete();
    for (int p = 0; p < 3; p++) begin
      req[p][0] = 1'b1; op[p][0] = 4; dvc[p][0] = p;
    end
    repeat (6) step(1'b1);
    clear_stim();
    step(1'b1);
    check("out_fair_count", seq_ip4.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < seq_ip4.size()) check("out_fair_order", seq_ip4[i], exp_seq4[i]);
    end

    // VC fairness inside in1
    step(1'b0);
    step(1'b1);
    seq_vc1.delete();
    req[1][0] = 1'b1; op[1][0] = 2; dvc[1][0] = 0;
    req[1][3] = 1'b1; op[1][3] = 0; dvc[1][3] = 0;
    repeat (4) step(1'b1);
    clear_stim();
    step(1'b1);
    check("vc_fair_count", seq_vc1.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < seq_vc1.size()) check("vc_fair_order", seq_vc1[i], exp_seq1[i]);
    end

    // Credit edge cases
    step(1'b0);
    step(1'b1);
    req[0][0] = 1'b1; op[0][0] = 1; dvc[0][0] = 2;
    cr_v[1] = 1'b1; cr_vc[1] = 2;
    step(1'b1);
    clear_stim();
    step(1'b1);
    check("grant_and_return_no_err", ifc.credit_err_o, 0);
    cr_v[1] = 1'b1; cr_vc[1] = 2;
    step(1'b1);
    clear_stim();
    step(1'b1);
    check("overflow_sets_err", ifc.credit_err_o, 1);
    req[2][1] = 1'b1; op[2][1] = 0; dvc[2][1] = 3;
    repeat (3) step(1'b1);
    check("err_sticky", ifc.credit_err_o, 1);
    @(posedge clk);
    #3;
    check("grant_before_reset", ifc.valid_sel_o[2], 1);
    rst = 1'b0;
    exp_q.delete();
    model_reset();
    #1;
    check("midburst_reset_clears", act_vec(), '0);
    clear_stim();
    step(1'b0);
    step(1'b1);

    // Randomized traffic with occasional resets
    for (int n = 0; n < 400; n++) begin
      randomize_stim(50, 35);
      step((n % 100) != 99);
    end

    clear_stim();
    step(1'b1);
    step(1'b1);
    @(posedge clk);
    #2;
    check("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
